// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage of the LoongArch core.
// Owns the PC, issues reads to the synchronous instruction SRAM, and hands one
// {pc, inst} pair per cycle to decode. Branch redirects from decode discard the
// current slot. A one-entry hold buffer keeps the word stable while decode stalls.
//
// Optional feature macro: IF_ADE_CHECK_EN
//   defined   : a misaligned next PC suppresses the SRAM read, the slot is loaded
//               with fs_ade set and fs_inst forced to zero.
//   undefined : low PC bits are ignored on the SRAM address, fs_ade is tied 0.
//
// Handshake to decode: fs_to_ds_valid is asserted whenever the slot holds a
// right-path instruction; the transfer completes on a cycle where both
// fs_to_ds_valid and ds_allowin are 1. fs_to_ds_valid never depends on
// ds_allowin. A redirect (br_taken) drops the slot in the same cycle, so a
// wrong-path instruction is never presented as valid.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_ade,
    output logic        inst_sram_en,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    // PC value held before the first fetch so that fs_pc + 4 lands on RESET_PC.
    localparam logic [31:0] PRE_RESET_PC = RESET_PC - 32'd4;

    logic        fs_valid;
    logic        req_last;
    logic        buf_valid;
    logic [31:0] inst_buf;
    logic        ade_r;

    logic [31:0] nextpc;
    logic        fs_allowin;
    logic        hold_capture;
    logic        nextpc_misaligned;
    logic [31:0] inst_sel;

    // Next-PC selection: redirect target wins, otherwise sequential (wraps mod 2^32).
    always_comb begin
        nextpc = fs_pc + 32'd4;
        if (br_taken) begin
            nextpc = br_target;
        end
    end

    // The slot can be refilled when empty, drained by decode, or flushed by a redirect.
    always_comb begin
        fs_allowin   = ~fs_valid | ds_allowin | br_taken;
        // First stall cycle: the SRAM word for the slot is on rdata now and
        // will be gone next cycle, so park it in the hold buffer.
        hold_capture = fs_valid & req_last & ~ds_allowin & ~br_taken;
    end

`ifdef IF_ADE_CHECK_EN
    // Misaligned fetch address: the read is suppressed and the slot is flagged.
    always_comb begin
        nextpc_misaligned = (nextpc[1:0] != 2'b00);
    end
`else
    // Low PC bits play no part in fetch when the address check is disabled.
    always_comb begin
        nextpc_misaligned = 1'b0;
    end
`endif

    // SRAM request port: read-only, address is the PC being loaded into the slot.
    always_comb begin
        inst_sram_en    = fs_allowin & ~reset & ~nextpc_misaligned;
        inst_sram_we    = 1'b0;
        inst_sram_wdata = 32'h0;
`ifdef IF_ADE_CHECK_EN
        inst_sram_addr  = nextpc;
`else
        inst_sram_addr  = {nextpc[31:2], 2'b00};
`endif
    end

    // Slot, PC and request-tracking registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_valid <= 1'b0;
            fs_pc    <= PRE_RESET_PC;
            req_last <= 1'b0;
            ade_r    <= 1'b0;
        end else if (fs_allowin) begin
            fs_valid <= 1'b1;
            fs_pc    <= nextpc;
            req_last <= 1'b1;
            ade_r    <= nextpc_misaligned;
        end else begin
            req_last <= 1'b0;
        end
    end

    // Hold buffer: filled on the first stall cycle, released whenever the slot reloads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            inst_buf  <= 32'h0;
        end else if (fs_allowin) begin
            buf_valid <= 1'b0;
        end else if (hold_capture) begin
            buf_valid <= 1'b1;
            inst_buf  <= inst_sram_rdata;
        end
    end

    // Delivered word: buffered copy while stalled, live SRAM data otherwise;
    // an address-error slot carries a zero word.
    always_comb begin
        inst_sel = buf_valid ? inst_buf : inst_sram_rdata;
        fs_inst  = ade_r ? 32'h0 : inst_sel;
        fs_ade   = ade_r;
    end

    // Valid to decode, masked in the redirect cycle so the wrong-path slot is dropped.
    always_comb begin
        fs_to_ds_valid = fs_valid & ~br_taken;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage for the LoongArch CPU core. It owns the PC, issues requests to the synchronous instruction SRAM, and delivers one `{pc, inst}` pair per cycle to the decode stage through a valid/allowin handshake. It takes branch redirects from decode and drops wrong-path instructions. A one-entry hold buffer keeps a fetched instruction stable while decode stalls.

## Interface
- `RESET_PC`, default 32'h1c00_0000, address of the first fetched instruction.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `ds_allowin` in 1: decode can accept an instruction this cycle.
- `br_taken` in 1: redirect request from decode, single-cycle pulse.
- `br_target` in 32: redirect address, sampled when `br_taken`=1.
- `fs_to_ds_valid` out 1: `fs_pc`/`fs_inst` are valid for decode.
- `fs_pc` out 32: PC of the delivered instruction.
- `fs_inst` out 32: delivered instruction word.
- `fs_ade` out 1: fetch address error flag for the delivered slot (see Configuration).
- `inst_sram_en` out 1: SRAM read enable.
- `inst_sram_we` out 1: tied 0.
- `inst_sram_addr` out 32: SRAM read address.
- `inst_sram_wdata` out 32: tied 0.
- `inst_sram_rdata` in 32: SRAM data, valid the cycle after an enabled request.

## Operation
- State registers:
  - `fs_valid`: slot occupied.
  - `fs_pc`.
  - `req_last`: a request was issued in the previous cycle.
  - `buf_valid` and `inst_buf`.
- `nextpc = br_taken ? br_target : fs_pc + 4`. The adder is 32-bit and wraps modulo 2^32.
- `fs_allowin = ~fs_valid | ds_allowin | br_taken`. On `br_taken`, the current slot is discarded.
- `inst_sram_en = fs_allowin & ~reset`. `inst_sram_addr = nextpc`.
- On a clock edge with `fs_allowin`=1:
  - `fs_pc <= nextpc`
  - `fs_valid <= 1`
  - `req_last <= 1`
  - `buf_valid <= 0`
- Otherwise `req_last <= 0`.
- Hold buffer: if `fs_valid & req_last & ~ds_allowin & ~br_taken`, then `inst_buf <= inst_sram_rdata` and `buf_valid <= 1`.
- Output mux: `fs_inst = buf_valid ? inst_buf : inst_sram_rdata`.
- `fs_to_ds_valid = fs_valid & ~br_taken`. A wrong-path instruction is never delivered.
- A handshake completes when `fs_to_ds_valid & ds_allowin`.
- Simultaneous `br_taken` and `ds_allowin`=0: the redirect still wins. The target is requested and the slot is overwritten.
- Reset values:
  - `fs_valid`=0, `fs_pc`=RESET_PC-4, `req_last`=0, `buf_valid`=0, `inst_buf`=0.
  - Outputs: `fs_to_ds_valid`=0, `inst_sram_en`=0, `fs_ade`=0.
- Reset asserted mid-operation clears all state immediately (asynchronous). In-flight SRAM data is ignored.

## Timing
- Cycle 0 after reset release:
  - `inst_sram_en`=1.
  - `inst_sram_addr`=RESET_PC.
- Cycle 1:
  - `fs_to_ds_valid`=1, `fs_pc`=RESET_PC, `fs_inst`=SRAM data.
- Fetch-to-delivery latency is 1 cycle. Throughput is 1 instruction/cycle when `ds_allowin`=1.
- Stall: the delivered word is held from `inst_buf` for every cycle after the first stall cycle. No SRAM request is issued while stalled.
- Redirect:
  - `br_taken` in cycle N causes `inst_sram_addr`=`br_target` in cycle N.
  - The target instruction is delivered in cycle N+1.
  - Exactly zero wrong-path instructions reach decode.

## Configuration
- Macro `IF_ADE_CHECK_EN`.
- Defined:
  - If `nextpc[1:0]`≠0, `inst_sram_en` is forced to 0.
  - The slot is still loaded, and a registered `ade_r` is set.
  - `fs_ade`=`ade_r`, and `fs_inst` is forced to 32'h0 for that slot.
  - The next address is `fs_pc+4`, unless a redirect occurs.
- Undefined:
  - `fs_ade` is tied 0.
  - `inst_sram_addr = {nextpc[31:2], 2'b00}`.
  - Low PC bits are ignored.

## Test plan
- Reset release, `ds_allowin`=1, SRAM returns addr^32'hFFFF_FFFF -> cycle 1 delivers pc 1c000000. Consecutive cycles deliver pc 1c000004, 1c000008 with matching inst.
- `ds_allowin`=0 for 3 cycles after pc 1c000004 is fetched, while SRAM output is driven to garbage in the stalled cycles -> `fs_inst` stays equal to the word at 1c000004, and `inst_sram_en`=0. On release, the next delivery is 1c000008.
- `br_taken`=1 with `br_target`=1c000100 while pc 1c000008 is in the slot -> 1c000008 is not delivered (`fs_to_ds_valid`=0 that cycle). The next cycle delivers pc 1c000100.
- `br_taken`=1 while `ds_allowin`=0 and `buf_valid`=1 -> the buffer is cleared, and the next cycle delivers `br_target` with fresh SRAM data.
- Reset asserted asynchronously mid-stream (between edges) -> `fs_to_ds_valid` and `inst_sram_en` go to 0 immediately. After release, fetch restarts at 1c000000.
- With `IF_ADE_CHECK_EN` defined, `br_target`=1c000102 -> no SRAM enable. The next cycle has `fs_ade`=1, `fs_inst`=0 and `fs_pc`=1c000102. Without the macro, `inst_sram_addr`=1c000100 and `fs_ade`=0.
